// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo up/down counter family.
package mod_counter_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mod_counter_updn.sv
// Modulo-N up/down counter with load, wrap/saturate mode, terminal count
// for cascading, a one-cycle wrap pulse and a saturating wrap tally.
module mod_counter_updn
  import mod_counter_pkg::*;
#(
  parameter int MODULO   = 7,
  parameter int WIDTH    = $clog2(MODULO),
  parameter int SATURATE = MODE_WRAP,
  parameter int WCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              wrapped,
  output logic [WCNT_W-1:0] wrap_cnt
);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULO - 1);
  // one extra bit so MODULO itself is representable when it is a power of two
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULO);

  generate
    if (MODULO < 2 || (SATURATE != MODE_WRAP && SATURATE != MODE_SAT)) begin : g_bad_param
      $error("mod_counter_updn: MODULO must be >= 2 and SATURATE 0 or 1");
    end
  endgenerate

  logic             at_end;
  logic             wrap;
  logic [WIDTH-1:0] out_nxt;

  assign at_end = (up == DIR_UP) ? (out == MAX) : (out == '0);
  assign tc     = ce & at_end;
  // a load in the same cycle as tc pre-empts the wrap entirely
  assign wrap   = !load && tc && (SATURATE == MODE_WRAP);

  always_comb begin
    out_nxt = out;
    if (load)
      out_nxt = ({1'b0, load_val} < MOD_X) ? load_val : MAX;
    else if (tc)
      out_nxt = (SATURATE == MODE_SAT) ? out : ((up == DIR_UP) ? '0 : MAX);
    else if (ce)
      out_nxt = (up == DIR_UP) ? out + 1'b1 : out - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= '0;
      wrapped <= 1'b0;
    end else begin
      out     <= out_nxt;
      wrapped <= wrap;
    end
  end

  sat_counter #(.W(WCNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap),
    .cnt (wrap_cnt)
  );
endmodule

// File: tb/tb_mod_counter_updn.sv
// Self-checking bench: directed scenarios plus randomized traffic against an arithmetic model.
module tb_mod_counter_updn;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // A: MODULO=7 wrap, B: MODULO=5 saturate, D: MODULO=2 with 2-bit tally, lo/hi: cascade
  logic       a_ce = 0, a_up = 0, a_ld = 0; logic [2:0] a_lv = '0;
  logic [2:0] a_out; logic a_tc, a_wr; logic [7:0] a_wc;
  logic       b_ce = 0, b_up = 0, b_ld = 0; logic [2:0] b_lv = '0;
  logic [2:0] b_out; logic b_tc, b_wr; logic [7:0] b_wc;
  logic       d_ce = 0, d_up = 0, d_ld = 0; logic [0:0] d_lv = '0;
  logic [0:0] d_out; logic d_tc, d_wr; logic [1:0] d_wc;
  logic       c_ce = 0;
  logic [3:0] lo_out, hi_out; logic lo_tc, hi_tc, lo_wr, hi_wr; logic [7:0] lo_wc, hi_wc;

  mod_counter_updn #(.MODULO(7)) u_a (.clk(clk), .rst(rst), .ce(a_ce), .up(a_up), .load(a_ld),
    .load_val(a_lv), .out(a_out), .tc(a_tc), .wrapped(a_wr), .wrap_cnt(a_wc));
  mod_counter_updn #(.MODULO(5), .SATURATE(1)) u_b (.clk(clk), .rst(rst), .ce(b_ce), .up(b_up),
    .load(b_ld), .load_val(b_lv), .out(b_out), .tc(b_tc), .wrapped(b_wr), .wrap_cnt(b_wc));
  mod_counter_updn #(.MODULO(2), .WCNT_W(2)) u_d (.clk(clk), .rst(rst), .ce(d_ce), .up(d_up),
    .load(d_ld), .load_val(d_lv), .out(d_out), .tc(d_tc), .wrapped(d_wr), .wrap_cnt(d_wc));
  mod_counter_updn #(.MODULO(10)) u_lo (.clk(clk), .rst(rst), .ce(c_ce), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .out(lo_out), .tc(lo_tc), .wrapped(lo_wr), .wrap_cnt(lo_wc));
  mod_counter_updn #(.MODULO(10)) u_hi (.clk(clk), .rst(rst), .ce(lo_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .out(hi_out), .tc(hi_tc), .wrapped(hi_wr), .wrap_cnt(hi_wc));

  int errors = 0;
  int checks = 0;

  typedef struct { int v; int wc; bit wr; } cst_t;
  cst_t ma, mb, md, mlo, mhi;

  // counter as modular arithmetic: v in Z_m, wraps tallied up to wmax
  function automatic cst_t nxt(cst_t s, int m, bit sat, int wmax, bit ce, bit up, bit ld, int lv);
    cst_t r;
    bit   boundary;
    r = s;
    r.wr = 1'b0;
    if (ld) r.v = (lv < m) ? lv : m - 1;
    else if (ce) begin
      boundary = up ? (s.v == m - 1) : (s.v == 0);
      if (!boundary) r.v = (s.v + (up ? 1 : m - 1)) % m;
      else if (!sat) begin
        r.v  = (s.v + (up ? 1 : m - 1)) % m;
        r.wr = 1'b1;
        if (r.wc < wmax) r.wc = r.wc + 1;
      end
    end
    return r;
  endfunction

  function automatic bit mtc(cst_t s, int m, bit ce, bit up);
    return ce && (up ? (s.v == m - 1) : (s.v == 0));
  endfunction

  function automatic cst_t zero_st();
    cst_t z;
    z.v = 0; z.wc = 0; z.wr = 1'b0;
    return z;
  endfunction

  task automatic zero_models();
    ma = zero_st(); mb = zero_st(); md = zero_st(); mlo = zero_st(); mhi = zero_st();
  endtask

  task automatic tick();
    bit hce;
    hce = mtc(mlo, 10, c_ce, 1'b1);
    @(posedge clk);
    if (rst) begin
      ma  = nxt(ma, 7, 1'b0, 255, a_ce, a_up, a_ld, int'(a_lv));
      mb  = nxt(mb, 5, 1'b1, 255, b_ce, b_up, b_ld, int'(b_lv));
      md  = nxt(md, 2, 1'b0, 3, d_ce, d_up, d_ld, int'(d_lv));
      mlo = nxt(mlo, 10, 1'b0, 255, c_ce, 1'b1, 1'b0, 0);
      mhi = nxt(mhi, 10, 1'b0, 255, hce, 1'b1, 1'b0, 0);
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_ce = 0; a_up = 0; a_ld = 0; a_lv = '0;
    b_ce = 0; b_up = 0; b_ld = 0; b_lv = '0;
    d_ce = 0; d_up = 0; d_ld = 0; d_lv = '0;
    c_ce = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    zero_models();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    zero_models();
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_out, a_wr, a_wc, b_out, b_wc, d_out, d_wc, lo_out, hi_out, lo_wc} !== '0) begin
      errors++;
      $display("FAIL reset_state: a_out=%0d a_wr=%0b a_wc=%0d b_out=%0d lo=%0d hi=%0d, want all 0",
               a_out, a_wr, a_wc, b_out, lo_out, hi_out);
    end
    a_ce = 1; a_up = 0; #1;
    checks++;
    if (a_tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: tc=%0b want 1", a_tc); end
    a_up = 1; #1;
    checks++;
    if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: tc=%0b want 0", a_tc); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    int pulses;
    pulses = 0;
    do_reset();
    a_ce = 1; a_up = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (a_out !== 3'(k % 7)) begin
        errors++; $display("FAIL up_wrap_out: cycle %0d out=%0d want %0d", k, a_out, k % 7);
      end
      if (a_wr === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL up_wrap_pulses: saw %0d want 2", pulses); end
    checks++;
    if (a_wc !== 8'd2) begin errors++; $display("FAIL up_wrap_cnt: wrap_cnt=%0d want 2", a_wc); end
    idle_inputs();
  endtask

  task automatic test_down_load();
    int exp_seq [6] = '{3, 2, 1, 0, 6, 5};
    a_ld = 1; a_lv = 3'd3; a_ce = 0;
    tick();
    a_ld = 0; a_ce = 1; a_up = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      #1;
      checks++;
      if (a_out !== 3'(exp_seq[k]) || a_tc !== (exp_seq[k] == 0)) begin
        errors++;
        $display("FAIL down_load: step %0d out=%0d tc=%0b want out=%0d tc=%0b",
                 k, a_out, a_tc, exp_seq[k], exp_seq[k] == 0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clamp_priority();
    int wc_before;
    a_ld = 1; a_lv = 3'd7; b_ld = 1; b_lv = 3'd6;
    tick();
    checks++;
    if (a_out !== 3'd6 || b_out !== 3'd4) begin
      errors++; $display("FAIL load_clamp: a_out=%0d b_out=%0d want 6 and 4", a_out, b_out);
    end
    a_ld = 0; b_ld = 0; a_ce = 1; a_up = 1; #1;
    checks++;
    if (a_tc !== 1'b1) begin errors++; $display("FAIL clamp_tc: tc=%0b want 1", a_tc); end
    wc_before = int'(a_wc);
    a_ld = 1; a_lv = 3'd2;
    tick();
    checks++;
    if (a_out !== 3'd2 || a_wr !== 1'b0 || int'(a_wc) != wc_before) begin
      errors++;
      $display("FAIL load_over_tc: out=%0d wrapped=%0b wrap_cnt=%0d want 2 0 %0d",
               a_out, a_wr, a_wc, wc_before);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    b_ce = 1; b_up = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (b_out !== 3'((k < 4) ? k : 4) || b_wr !== 1'b0) begin
        errors++; $display("FAIL saturate_out: cycle %0d out=%0d wrapped=%0b want %0d 0",
                           k, b_out, b_wr, (k < 4) ? k : 4);
      end
    end
    checks++;
    if (b_tc !== 1'b1 || b_wc !== 8'd0) begin
      errors++; $display("FAIL saturate_end: tc=%0b wrap_cnt=%0d want 1 0", b_tc, b_wc);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_ce = ($urandom_range(0, 3) != 0); a_up = 1'($urandom); a_ld = ($urandom_range(0, 9) == 0);
      a_lv = 3'($urandom);
      b_ce = ($urandom_range(0, 3) != 0); b_up = 1'($urandom); b_ld = ($urandom_range(0, 9) == 0);
      b_lv = 3'($urandom);
      d_ce = ($urandom_range(0, 7) != 0); d_up = 1'($urandom); d_ld = ($urandom_range(0, 15) == 0);
      d_lv = 1'($urandom);
      #1;
      checks++;
      if (a_tc !== mtc(ma, 7, a_ce, a_up) || b_tc !== mtc(mb, 5, b_ce, b_up) ||
          d_tc !== mtc(md, 2, d_ce, d_up)) begin
        errors++; $display("FAIL rand_tc: cycle %0d a=%0b b=%0b d=%0b", k, a_tc, b_tc, d_tc);
      end
      tick();
      checks++;
      if (a_out !== 3'(ma.v) || a_wr !== ma.wr || a_wc !== 8'(ma.wc)) begin
        errors++; $display("FAIL rand_a: cycle %0d out=%0d wr=%0b wc=%0d want %0d %0b %0d",
                           k, a_out, a_wr, a_wc, ma.v, ma.wr, ma.wc);
      end
      checks++;
      if (b_out !== 3'(mb.v) || b_wr !== mb.wr || b_wc !== 8'(mb.wc)) begin
        errors++; $display("FAIL rand_b: cycle %0d out=%0d wr=%0b wc=%0d want %0d %0b %0d",
                           k, b_out, b_wr, b_wc, mb.v, mb.wr, mb.wc);
      end
      checks++;
      if (d_out !== 1'(md.v) || d_wr !== md.wr || d_wc !== 2'(md.wc)) begin
        errors++; $display("FAIL rand_d: cycle %0d out=%0d wr=%0b wc=%0d want %0d %0b %0d",
                           k, d_out, d_wr, d_wc, md.v, md.wr, md.wc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    d_ce = 1; d_up = 1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (d_wr !== 1'b1 || d_out !== 1'b0) begin
        errors++; $display("FAIL b2b_wrap: cycle %0d wrapped=%0b out=%0d want 1 0", k, d_wr, d_out);
      end
      tick();
    end
    checks++;
    if (d_wc !== 2'd3) begin errors++; $display("FAIL wrap_cnt_sat: wrap_cnt=%0d want 3", d_wc); end
    idle_inputs();
  endtask

  task automatic test_midreset();
    do_reset();
    a_ce = 1; a_up = 1;
    repeat (20) tick();
    checks++;
    if (a_out !== 3'd6) begin errors++; $display("FAIL midreset_pre: out=%0d want 6", a_out); end
    rst = 1'b0;
    zero_models();
    #1;
    checks++;
    if (a_out !== 3'd0 || a_wr !== 1'b0 || a_wc !== 8'd0) begin
      errors++; $display("FAIL midreset_async: out=%0d wr=%0b wc=%0d want 0 0 0", a_out, a_wr, a_wc);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (a_out !== 3'd1 || a_wr !== 1'b0) begin
      errors++; $display("FAIL midreset_resume: out=%0d wr=%0b want 1 0", a_out, a_wr);
    end
    idle_inputs();
  endtask

  task automatic test_cascade();
    do_reset();
    c_ce = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      checks++;
      if (lo_out !== 4'(k % 10) || hi_out !== 4'((k / 10) % 10)) begin
        errors++; $display("FAIL cascade: cycle %0d lo=%0d hi=%0d want %0d %0d",
                           k, lo_out, hi_out, k % 10, (k / 10) % 10);
      end
    end
    checks++;
    if (lo_wc !== 8'd10 || hi_wc !== 8'd1) begin
      errors++; $display("FAIL cascade_wraps: lo_wc=%0d hi_wc=%0d want 10 1", lo_wc, hi_wc);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_load();
    test_clamp_priority();
    test_saturate();
    do_reset();
    test_random();
    test_back_to_back_wrap();
    test_midreset();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
